// File: rtl/tff_pkg.sv
// Shared types for the T flip-flop counter: the mode encoding and its width.
package tff_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    HOLD = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10,
    MASK = 2'b11
  } mode_e;

endpackage : tff_pkg

// File: rtl/tff_cell.sv
// Single T flip-flop stage with synchronous reset value and parallel load.
// Priority on each rising edge: rst > ld > t.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic ld,
  input  logic d,
  input  logic t,
  output logic q
);

  logic q_d;
  logic q_q;

  // NOTE: every path assigns q_d, starting from a default, so no latch is inferred.
  always_comb begin
    q_d = q_q;
    if (rst) begin
      q_d = rst_val;
    end else if (ld) begin
      q_d = d;
    end else if (t) begin
      q_d = ~q_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule : tff_cell

// File: rtl/tff_counter.sv
// Up/down/mask counter built from WIDTH T flip-flop stages with the carry
// network in this module. Define TFF_COUNTER_SAT_EN to saturate at the limits
// instead of wrapping.
module tff_counter
  import tff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  t_mask,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  q,
  output logic              tc,
  output logic              ovf
);

  mode_e            mode_s;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] toggle;
  logic             at_max;
  logic             at_min;
  logic             ovf_d;
  logic             ovf_q;

  assign mode_s = mode_e'(mode);
  assign at_max = &q;
  assign at_min = ~|q;

  // Stage i toggles when every lower stage is 1 (up) or 0 (down).
  always_comb begin
    logic up_c;
    logic dn_c;
    up_c = 1'b1;
    dn_c = 1'b1;
    up_t = '0;
    dn_t = '0;
    for (int i = 0; i < WIDTH; i++) begin
      up_t[i] = up_c;
      dn_t[i] = dn_c;
      up_c    = up_c & q[i];
      dn_c    = dn_c & ~q[i];
    end
  end

  always_comb begin
    toggle = '0;
    ovf_d  = 1'b0;
    if (!rst && !load && en) begin
      case (mode_s)
        UP: begin
          ovf_d = at_max;
`ifdef TFF_COUNTER_SAT_EN
          toggle = at_max ? '0 : up_t;
`else
          toggle = up_t;
`endif
        end
        DOWN: begin
          ovf_d = at_min;
`ifdef TFF_COUNTER_SAT_EN
          toggle = at_min ? '0 : dn_t;
`else
          toggle = dn_t;
`endif
        end
        MASK:    toggle = t_mask;
        default: toggle = '0;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    tff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RST_VAL[i]),
      .ld      (load),
      .d       (load_val[i]),
      .t       (toggle[i]),
      .q       (q[i])
    );
  end

  always_ff @(posedge clk) begin
    ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
  assign tc  = ((mode_s == UP) && at_max) || ((mode_s == DOWN) && at_min);

endmodule : tff_counter

// File: tb/tb_tff_counter.sv
// Self-checking bench for tff_counter (WIDTH=4, RST_VAL=5): directed vector
// table, hand-written terminal-count sequence, then random stimulus vs. a model.
module tb_tff_counter;

  localparam int         W       = 4;
  localparam logic [3:0] RV      = 4'h5;
  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_UP    = 2'b01;
  localparam logic [1:0] M_DOWN  = 2'b10;
  localparam logic [1:0] M_MASK  = 2'b11;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] t_mask;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         tc;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tff_counter #(.WIDTH(W), .RST_VAL(RV)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .t_mask   (t_mask),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc),
    .ovf      (ovf)
  );

  typedef struct {
    logic       rst;
    logic       load;
    logic       en;
    logic [1:0] mode;
    logic [3:0] t_mask;
    logic [3:0] load_val;
    logic [3:0] exp_q;
    logic       exp_ovf;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  function automatic vec_t mk(logic r, logic l, logic e, logic [1:0] m,
                              logic [3:0] tm, logic [3:0] lv,
                              logic [3:0] eq, logic eo);
    vec_t v;
    v.rst = r; v.load = l; v.en = e; v.mode = m;
    v.t_mask = tm; v.load_val = lv; v.exp_q = eq; v.exp_ovf = eo;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic l, input logic e, input logic [1:0] m,
                       input logic [3:0] tm, input logic [3:0] lv);
    rst = r; load = l; en = e; mode = m; t_mask = tm; load_val = lv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: next state from the counting rules in plain arithmetic.
  int mq;
  bit movf;

  task automatic model_step(input logic r, input logic l, input logic e, input logic [1:0] m,
                            input logic [3:0] tm, input logic [3:0] lv);
    int nxt;
    movf = 1'b0;
    if (r) begin
      mq = RV;
    end else if (l) begin
      mq = lv;
    end else if (e) begin
      case (m)
        M_UP: begin
          nxt = mq + 1;
          if (nxt > 15) begin
            movf = 1'b1;
`ifndef TFF_COUNTER_SAT_EN
            mq = nxt - 16;
`endif
          end else begin
            mq = nxt;
          end
        end
        M_DOWN: begin
          nxt = mq - 1;
          if (nxt < 0) begin
            movf = 1'b1;
`ifndef TFF_COUNTER_SAT_EN
            mq = nxt + 16;
`endif
          end else begin
            mq = nxt;
          end
        end
        M_MASK:  mq = mq ^ int'(tm);
        default: ;
      endcase
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, M_HOLD, 4'h0, 4'h0);

    vecs[0]  = mk(1, 0, 1, M_UP,   4'h0, 4'h0, 4'h5, 0);
    vecs[1]  = mk(0, 0, 1, M_UP,   4'h0, 4'h0, 4'h6, 0);
    vecs[2]  = mk(1, 1, 1, M_UP,   4'h0, 4'h7, 4'h5, 0);
    vecs[3]  = mk(0, 1, 1, M_UP,   4'h0, 4'h7, 4'h7, 0);
    vecs[4]  = mk(0, 0, 0, M_UP,   4'h0, 4'h0, 4'h7, 0);
    vecs[5]  = mk(0, 0, 1, M_HOLD, 4'hF, 4'h0, 4'h7, 0);
    vecs[6]  = mk(0, 1, 0, M_HOLD, 4'h0, 4'hE, 4'hE, 0);
    vecs[7]  = mk(0, 0, 1, M_UP,   4'h0, 4'h0, 4'hF, 0);
`ifdef TFF_COUNTER_SAT_EN
    vecs[8]  = mk(0, 0, 1, M_UP,   4'h0, 4'h0, 4'hF, 1);
    vecs[9]  = mk(0, 0, 1, M_UP,   4'h0, 4'h0, 4'hF, 1);
`else
    vecs[8]  = mk(0, 0, 1, M_UP,   4'h0, 4'h0, 4'h0, 1);
    vecs[9]  = mk(0, 0, 1, M_UP,   4'h0, 4'h0, 4'h1, 0);
`endif
    vecs[10] = mk(0, 1, 0, M_HOLD, 4'h0, 4'hA, 4'hA, 0);
    vecs[11] = mk(0, 0, 1, M_MASK, 4'h3, 4'h0, 4'h9, 0);
    vecs[12] = mk(0, 0, 1, M_MASK, 4'h3, 4'h0, 4'hA, 0);
    vecs[13] = mk(0, 1, 1, M_MASK, 4'hF, 4'h1, 4'h1, 0);
    vecs[14] = mk(0, 0, 1, M_DOWN, 4'h0, 4'h0, 4'h0, 0);
`ifdef TFF_COUNTER_SAT_EN
    vecs[15] = mk(0, 0, 1, M_DOWN, 4'h0, 4'h0, 4'h0, 1);
    vecs[16] = mk(0, 0, 1, M_DOWN, 4'h0, 4'h0, 4'h0, 1);
`else
    vecs[15] = mk(0, 0, 1, M_DOWN, 4'h0, 4'h0, 4'hF, 1);
    vecs[16] = mk(0, 0, 1, M_DOWN, 4'h0, 4'h0, 4'hE, 0);
`endif
    vecs[17] = mk(0, 1, 1, M_DOWN, 4'h0, 4'h0, 4'h0, 0);
    vecs[18] = mk(0, 0, 1, M_MASK, 4'h0, 4'h0, 4'h0, 0);
    vecs[19] = mk(1, 0, 1, M_UP,   4'h0, 4'h0, 4'h5, 0);
    vecs[20] = mk(0, 0, 1, M_UP,   4'h0, 4'h0, 4'h6, 0);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].mode,
            vecs[i].t_mask, vecs[i].load_val);
      tick();
      check($sformatf("vec%0d_q", i),   32'(q),   32'(vecs[i].exp_q));
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
    end

    // Terminal count is combinational on q and mode, independent of en.
    drive(0, 1, 0, M_HOLD, 4'h0, 4'hF);
    tick();
    check("tc_hold_f", 32'(tc), 32'd0);
    drive(0, 0, 0, M_UP, 4'h0, 4'h0);
    #1 check("tc_up_f", 32'(tc), 32'd1);
    drive(0, 0, 0, M_DOWN, 4'h0, 4'h0);
    #1 check("tc_down_f", 32'(tc), 32'd0);
    drive(0, 1, 0, M_DOWN, 4'h0, 4'h0);
    tick();
    check("tc_down_0", 32'(tc), 32'd1);
    drive(0, 0, 0, M_MASK, 4'h0, 4'h0);
    #1 check("tc_mask_0", 32'(tc), 32'd0);
    drive(0, 0, 0, M_UP, 4'h0, 4'h0);
    #1 check("tc_up_0", 32'(tc), 32'd0);

    // Random stimulus against the reference model; first cycle resets.
    mq   = 0;
    movf = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic       r;
      logic       l;
      logic       e;
      logic [1:0] m;
      logic [3:0] tm;
      logic [3:0] lv;
      bit         exp_tc;
      r  = (n == 0) || ($urandom_range(0, 31) == 0);
      l  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 5) != 0);
      m  = 2'($urandom_range(0, 3));
      tm = 4'($urandom);
      lv = ($urandom_range(0, 1) == 0) ? 4'($urandom) : (($urandom_range(0, 1) == 0) ? 4'hF : 4'h0);
      drive(r, l, e, m, tm, lv);
      #1;
      if (n > 0) begin
        exp_tc = ((m == M_UP) && (mq == 15)) || ((m == M_DOWN) && (mq == 0));
        check($sformatf("rnd%0d_tc", n), 32'(tc), 32'(exp_tc));
      end
      model_step(r, l, e, m, tm, lv);
      tick();
      check($sformatf("rnd%0d_q", n),   32'(q),   32'(mq));
      check($sformatf("rnd%0d_ovf", n), 32'(ovf), 32'(movf));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_tff_counter
